fft_frame_collect: RTL

//  Upstream side of the FFT-to-analyzer interface. Accepts serial FFT bins, one per

---
 rtl/fft_frame_collect.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fft_frame_collect.sv
// Assembles 16 serial FFT bins into a frame and presents it with a 1-cycle fft_valid pulse (latency 1 after 16th accept).
// Backpressure: in_ready is low from the present cycle until ana_done; bins offered then are dropped and flag overrun.
module fft_frame_collect #(
    parameter int DW          = 16,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    output logic                 in_ready,
    input  logic                 ana_done,
    output logic                 fft_valid,
    output logic [2*DW-1:0]      fft_d0,
    output logic [2*DW-1:0]      fft_d1,
    output logic [2*DW-1:0]      fft_d2,
    output logic [2*DW-1:0]      fft_d3,
    output logic [2*DW-1:0]      fft_d4,
    output logic [2*DW-1:0]      fft_d5,
    output logic [2*DW-1:0]      fft_d6,
    output logic [2*DW-1:0]      fft_d7,
    output logic [2*DW-1:0]      fft_d8,
    output logic [2*DW-1:0]      fft_d9,
    output logic [2*DW-1:0]      fft_d10,
    output logic [2*DW-1:0]      fft_d11,
    output logic [2*DW-1:0]      fft_d12,
    output logic [2*DW-1:0]      fft_d13,
    output logic [2*DW-1:0]      fft_d14,
    output logic [2*DW-1:0]      fft_d15,
    output logic [7:0]           frame_cnt,
    output logic                 overrun
);

    typedef enum logic [1:0] {S_FILL = 2'd0, S_PRESENT = 2'd1, S_WAIT = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [2*DW-1:0] slot_q [16];
    logic [2*DW-1:0] slot_d [16];
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            overrun_q, overrun_d;
    logic            in_ready_q, in_ready_d;
    logic            fft_valid_q, fft_valid_d;
    logic            accept;

    function automatic logic [3:0] slot_of(input logic [3:0] k);
        slot_of = BIT_REVERSE ? {k[0], k[1], k[2], k[3]} : k;
    endfunction

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        slot_d      = slot_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q | (in_valid & ~in_ready_q);
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    slot_d[slot_of(idx_q)] = {in_real, in_imag};
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = S_PRESENT;
                    end
                end
            end
            S_PRESENT: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (ana_done) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        in_ready_d  = (state_d == S_FILL);
        fft_valid_d = (state_d == S_PRESENT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FILL;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            fft_valid_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            in_ready_q  <= in_ready_d;
            fft_valid_q <= fft_valid_d;
            for (int i = 0; i < 16; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign fft_valid = fft_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
    assign fft_d0    = slot_q[0];
    assign fft_d1    = slot_q[1];
    assign fft_d2    = slot_q[2];
    assign fft_d3    = slot_q[3];
    assign fft_d4    = slot_q[4];
    assign fft_d5    = slot_q[5];
    assign fft_d6    = slot_q[6];
    assign fft_d7    = slot_q[7];
    assign fft_d8    = slot_q[8];
    assign fft_d9    = slot_q[9];
    assign fft_d10   = slot_q[10];
    assign fft_d11   = slot_q[11];
    assign fft_d12   = slot_q[12];
    assign fft_d13   = slot_q[13];
    assign fft_d14   = slot_q[14];
    assign fft_d15   = slot_q[15];

endmodule
